fir_coeff_sequencer: RTL and testbench

Upstream control stage for the 4-tap transposed FIR (32×16 multiplies, 16-bit rounded output). It holds a writable shadow bank of 32-bit Q31 coefficients and, on command, shifts them serially into the filter over the filter's `load`/`cin_hi`/`cin_lo` port. It then streams 16-bit samples into the filter's `in` port at one per clock, inserting a zero and counting an underrun whenever the source has no sample. It drives every input of the filter except clock and reset.

---
 rtl/fir_coeff_sequencer.sv | 169 ++++++++++++++++
 tb/tb_fir_coeff_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coeff_sequencer.sv
// Control stage in front of the transposed FIR: keeps a writable shadow bank of
// Q31 coefficients, shifts a snapshot of it into the filter on commit, then
// streams samples one per clock. A zero is inserted and counted whenever the
// source has nothing to offer. Every output comes straight from a flop.
module fir_coeff_sequencer #(
  parameter int COEFF_SIZE = 4,
  parameter int ADDR_W     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic              commit,
  output logic              busy,
  output logic              coeff_valid,
  input  logic              s_valid,
  input  logic [15:0]       s_data,
  output logic              s_ready,
  output logic              load,
  output logic [15:0]       cin_hi,
  output logic [15:0]       cin_lo,
  output logic [15:0]       fir_in,
  output logic [15:0]       underrun_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Index is one bit wider than the address so it can reach COEFF_SIZE,
  // which marks the cycle after the last word has been presented.
  localparam logic [ADDR_W:0] NUM_TAPS = (ADDR_W + 1)'(COEFF_SIZE);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic              load_q, load_d;
  logic              busy_q, busy_d;
  logic              coeff_valid_q, coeff_valid_d;
  logic              s_ready_q, s_ready_d;
  logic [15:0]       cin_hi_q, cin_hi_d;
  logic [15:0]       cin_lo_q, cin_lo_d;
  logic [15:0]       fir_in_q, fir_in_d;
  logic [15:0]       underrun_q, underrun_d;
  logic              snapshot;
  logic              wr_ok;

  logic [31:0]       shadow_q [COEFF_SIZE];
  logic [31:0]       active_q [COEFF_SIZE];

  assign wr_ok = wr_en && ({1'b0, wr_addr} < NUM_TAPS);

  // Next-state and registered-output logic for the IDLE/LOAD/RUN sequencer.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; a missing default here would infer a latch.
    state_d       = state_q;
    idx_d         = idx_q;
    load_d        = 1'b1;
    busy_d        = 1'b0;
    coeff_valid_d = coeff_valid_q;
    s_ready_d     = 1'b0;
    cin_hi_d      = 16'h0000;
    cin_lo_d      = 16'h0000;
    fir_in_d      = 16'h0000;
    underrun_d    = underrun_q;
    snapshot      = 1'b0;

    case (state_q)
      IDLE: begin
        if (commit) begin
          snapshot   = 1'b1;
          underrun_d = 16'h0000;
          idx_d      = '0;
          state_d    = LOAD;
        end
      end

      LOAD: begin
        // Commit is deliberately not looked at here: no restart, no queuing.
        if (idx_q < NUM_TAPS) begin
          load_d               = 1'b0;
          busy_d               = 1'b1;
          {cin_hi_d, cin_lo_d} = active_q[idx_q[ADDR_W-1:0]];
          idx_d                = idx_q + 1'b1;
        end else begin
          coeff_valid_d = 1'b1;
          s_ready_d     = 1'b1;
          idx_d         = '0;
          state_d       = RUN;
        end
      end

      RUN: begin
        // s_ready is high throughout RUN, so this cycle's handshake is decided
        // by s_valid alone; a missing sample becomes a zero plus an underrun.
        if (s_valid) begin
          fir_in_d = s_data;
        end else if (underrun_q != 16'hFFFF) begin
          underrun_d = underrun_q + 16'd1;
        end
        if (commit) begin
          snapshot   = 1'b1;
          underrun_d = 16'h0000;
          idx_d      = '0;
          state_d    = LOAD;
        end else begin
          s_ready_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Control and output registers; reset aborts any load in progress.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      load_q        <= 1'b1;
      busy_q        <= 1'b0;
      coeff_valid_q <= 1'b0;
      s_ready_q     <= 1'b0;
      cin_hi_q      <= 16'h0000;
      cin_lo_q      <= 16'h0000;
      fir_in_q      <= 16'h0000;
      underrun_q    <= 16'h0000;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      load_q        <= load_d;
      busy_q        <= busy_d;
      coeff_valid_q <= coeff_valid_d;
      s_ready_q     <= s_ready_d;
      cin_hi_q      <= cin_hi_d;
      cin_lo_q      <= cin_lo_d;
      fir_in_q      <= fir_in_d;
      underrun_q    <= underrun_d;
    end
  end

  // Shadow and active coefficient banks; the snapshot sees pre-edge shadow
  // contents, so a write in the commit cycle lands in the shadow bank only.
  always_ff @(posedge clk) begin
    // NOTE: the banks are storage, not control state, so they carry no reset;
    // software must write every tap before the first commit.
    if (wr_ok) begin
      shadow_q[wr_addr] <= wr_data;
    end
    if (snapshot) begin
      active_q <= shadow_q;
    end
  end

  assign busy         = busy_q;
  assign coeff_valid  = coeff_valid_q;
  assign s_ready      = s_ready_q;
  assign load         = load_q;
  assign cin_hi       = cin_hi_q;
  assign cin_lo       = cin_lo_q;
  assign fir_in       = fir_in_q;
  assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_fir_coeff_sequencer.sv
// Self-checking bench for fir_coeff_sequencer: table-driven sample vectors,
// hand-written load/commit/reset sequences, and queues holding the expected
// coefficient words and samples.
module tb_fir_coeff_sequencer;

  localparam int COEFF  = 4;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              commit;
  logic              busy;
  logic              coeff_valid;
  logic              s_valid;
  logic [15:0]       s_data;
  logic              s_ready;
  logic              load;
  logic [15:0]       cin_hi;
  logic [15:0]       cin_lo;
  logic [15:0]       fir_in;
  logic [15:0]       underrun_cnt;

  fir_coeff_sequencer #(.COEFF_SIZE(COEFF), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .commit       (commit),
    .busy         (busy),
    .coeff_valid  (coeff_valid),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .load         (load),
    .cin_hi       (cin_hi),
    .cin_lo       (cin_lo),
    .fir_in       (fir_in),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s_valid;
    logic [15:0] s_data;
    logic [15:0] exp_fir;
    logic [15:0] exp_under;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [COEFF];
  logic [31:0] word_q [$];
  logic [15:0] sample_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_tap(input int addr, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(addr);
    wr_data = data;
    step();
    wr_en = 1'b0;
    model[addr] = data;
  endtask

  // Commit pulse; the expected load sequence is the model before this edge.
  task automatic do_commit();
    commit = 1'b1;
    for (int i = 0; i < COEFF; i++) word_q.push_back(model[i]);
    step();
    commit = 1'b0;
  endtask

  // Checks the LOAD words cycle by cycle, then the switch to RUN.
  // commit_at > 0 pulses commit while the commit_at-th word is visible.
  task automatic load_seq(input string tag, input int commit_at);
    logic [31:0] exp_w;
    for (int i = 0; i < COEFF; i++) begin
      step();
      check({tag, " load"},    32'(load),    32'd0);
      check({tag, " busy"},    32'(busy),    32'd1);
      check({tag, " s_ready"}, 32'(s_ready), 32'd0);
      check({tag, " fir_in"},  32'(fir_in),  32'd0);
      if (word_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s word: got %h expected none queued", tag, {cin_hi, cin_lo});
      end else begin
        exp_w = word_q.pop_front();
        check({tag, " word"}, {cin_hi, cin_lo}, exp_w);
      end
      commit = ((i + 1) == commit_at);
    end
    step();
    commit = 1'b0;
    check({tag, " done load"},        32'(load),         32'd1);
    check({tag, " done busy"},        32'(busy),         32'd0);
    check({tag, " done coeff_valid"}, 32'(coeff_valid),  32'd1);
    check({tag, " done s_ready"},     32'(s_ready),      32'd1);
    check({tag, " done underrun"},    32'(underrun_cnt), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " load"},        32'(load),         32'd1);
    check({tag, " busy"},        32'(busy),         32'd0);
    check({tag, " coeff_valid"}, 32'(coeff_valid),  32'd0);
    check({tag, " s_ready"},     32'(s_ready),      32'd0);
    check({tag, " cin"},         {cin_hi, cin_lo},  32'd0);
    check({tag, " fir_in"},      32'(fir_in),       32'd0);
    check({tag, " underrun"},    32'(underrun_cnt), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vecs [6];
    logic [15:0] exp_s;

    vecs[0] = '{1'b1, 16'd1, 16'd1, 16'd0};
    vecs[1] = '{1'b1, 16'd2, 16'd2, 16'd0};
    vecs[2] = '{1'b1, 16'd3, 16'd3, 16'd0};
    vecs[3] = '{1'b0, 16'hDEAD, 16'd0, 16'd1};
    vecs[4] = '{1'b0, 16'hBEEF, 16'd0, 16'd2};
    vecs[5] = '{1'b1, 16'd4, 16'd4, 16'd2};

    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    commit  = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    #1;
    check_reset_values("reset");
    step();
    step();
    reset = 1'b0;

    // IDLE ignores the source entirely.
    s_valid = 1'b1;
    s_data  = 16'h1234;
    for (int i = 0; i < 20; i++) begin
      step();
      check_reset_values("idle");
    end
    s_valid = 1'b0;

    // First load.
    write_tap(0, 32'h0001_0002);
    write_tap(1, 32'h0003_0004);
    write_tap(2, 32'h0005_0006);
    write_tap(3, 32'h0007_0008);
    do_commit();
    load_seq("load1", 0);

    // Sample stream through the scoreboard.
    for (int i = 0; i < 6; i++) begin
      s_valid = vecs[i].s_valid;
      s_data  = vecs[i].s_data;
      sample_q.push_back(vecs[i].exp_fir);
      step();
      exp_s = sample_q.pop_front();
      check($sformatf("run%0d fir_in", i), 32'(fir_in), 32'(exp_s));
      check($sformatf("run%0d underrun", i), 32'(underrun_cnt), 32'(vecs[i].exp_under));
      check($sformatf("run%0d s_ready", i), 32'(s_ready), 32'd1);
    end
    s_valid = 1'b1;
    s_data  = 16'h0042;

    // Write to tap 1 in the commit cycle: old value shifts out this time.
    wr_en   = 1'b1;
    wr_addr = 2'd1;
    wr_data = 32'hFFFF_8000;
    commit  = 1'b1;
    for (int i = 0; i < COEFF; i++) word_q.push_back(model[i]);
    step();
    wr_en    = 1'b0;
    commit   = 1'b0;
    model[1] = 32'hFFFF_8000;
    check("commit_cycle fir_in", 32'(fir_in), 32'h0042);
    load_seq("samecycle", 0);

    // Second commit shows the new tap 1.
    do_commit();
    load_seq("newtap", 0);

    // Commit during the 2nd LOAD cycle is ignored.
    do_commit();
    load_seq("ignore", 2);
    step();
    check("no_restart load", 32'(load), 32'd1);
    check("no_restart busy", 32'(busy), 32'd0);

    // Reset on the 3rd LOAD cycle aborts immediately.
    s_valid = 1'b0;
    do_commit();
    for (int i = 0; i < 3; i++) begin
      step();
      exp_s = 16'd0;
      check("abort load", 32'(load), 32'd0);
      check("abort word", {cin_hi, cin_lo}, word_q.pop_front());
    end
    reset = 1'b1;
    #1;
    check_reset_values("abort");
    word_q.delete();
    reset = 1'b0;
    step();
    check_reset_values("abort_idle");

    // Reload from IDLE using the retained shadow bank.
    do_commit();
    load_seq("reload", 0);

    // Underrun saturation, then cleared by commit.
    s_valid = 1'b0;
    for (int i = 0; i < 70000; i++) step();
    check("sat underrun", 32'(underrun_cnt), 32'h0000_FFFF);
    step();
    check("sat hold", 32'(underrun_cnt), 32'h0000_FFFF);
    do_commit();
    check("clear underrun", 32'(underrun_cnt), 32'd0);
    load_seq("postsat", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
